// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode and forward-select encodings for the 4-stage pipeline
// sequencing controller and its helpers.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] OP_ALU_OUT = 2'b00;
    localparam logic [1:0] OP_ALU     = 2'b01;
    localparam logic [1:0] OP_NOP     = 2'b10;
    localparam logic [1:0] OP_JMP     = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // Only the two ALU flavours write the register file.
    function automatic logic op_writes(input logic [1:0] op);
        return (op == OP_ALU_OUT) || (op == OP_ALU);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at
// all-ones instead of wrapping.
module sat_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: shadows EX and WB, derives stall, jump
// redirect/flush, operand forwarding selects and the two perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [1:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              out_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              pc_jmp_select,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ex_valid,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              out_valid,
    output logic [CNT_W-1:0]  jump_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [1:0]        ex_op;
    logic [REG_AW-1:0] ex_rd;
    logic [1:0]        wb_op;
    logic [REG_AW-1:0] wb_rd;

    logic stall;
    logic jump_take;
    logic ex_fwd_ok;
    logic wb_fwd_ok;

    // An output instruction parked in WB blocks the whole pipe until the
    // port accepts it; nothing else can stall.
    assign stall     = wb_valid && (wb_op == OP_ALU_OUT) && !out_ready;
    assign jump_take = id_valid && (id_opcode == OP_JMP) && !stall;

    assign pc_en         = !stall;
    assign ifid_en       = !stall;
    assign pc_jmp_select = jump_take;
    assign ifid_flush    = jump_take;

    assign out_valid    = wb_valid && (wb_op == OP_ALU_OUT);
    assign wb_reg_write = wb_valid && op_writes(wb_op) && !stall;

    // ---- ID -> EX -> WB shadow stages ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_op    <= 2'b00;
            ex_rd    <= '0;
            wb_valid <= 1'b0;
            wb_op    <= 2'b00;
            wb_rd    <= '0;
        end else if (!stall) begin
            ex_valid <= id_valid;
            ex_op    <= id_opcode;
            ex_rd    <= id_rd;
            wb_valid <= ex_valid;
            wb_op    <= ex_op;
            wb_rd    <= ex_rd;
        end
    end

    // ---- forwarding (EX is younger, so it wins over WB) ----
    assign ex_fwd_ok = ex_valid && op_writes(ex_op);
    assign wb_fwd_ok = wb_valid && op_writes(wb_op);

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_fwd_ok && (ex_rd == id_rs)) begin
            fwd_a = FWD_EX;
        end else if (wb_fwd_ok && (wb_rd == id_rs)) begin
            fwd_a = FWD_WB;
        end
        if (ex_fwd_ok && (ex_rd == id_rt)) begin
            fwd_b = FWD_EX;
        end else if (wb_fwd_ok && (wb_rd == id_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    // ---- performance counters ----
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_jump_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (jump_take),
        .count (jump_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: each vector pushes its
// hand-derived output snapshot; a monitor pops and compares mid-cycle.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [1:0] id_opcode;
    logic [2:0] id_rs;
    logic [2:0] id_rt;
    logic [2:0] id_rd;
    logic       out_ready;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       pc_jmp_select;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       ex_valid;
    logic       wb_valid;
    logic       wb_reg_write;
    logic       out_valid;
    logic [7:0] jump_cnt;
    logic [7:0] stall_cnt;

    pipe_hazard_ctrl #(
        .REG_AW (3),
        .CNT_W  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .out_ready     (out_ready),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .pc_jmp_select (pc_jmp_select),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .ex_valid      (ex_valid),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .out_valid     (out_valid),
        .jump_cnt      (jump_cnt),
        .stall_cnt     (stall_cnt)
    );

    // Field order: pc_en ifid_en ifid_flush pc_jmp_select fwd_a fwd_b
    // ex_valid wb_valid wb_reg_write out_valid jump_cnt stall_cnt
    typedef struct packed {
        logic       pc_en;
        logic       ifid_en;
        logic       flush;
        logic       jsel;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       exv;
        logic       wbv;
        logic       wr;
        logic       ov;
        logic [7:0] jc;
        logic [7:0] sc;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } item_t;

    item_t sb[$];
    int    n_vec;
    int    n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t o(int pc, int fi, int fl, int js, int fa, int fb,
                               int exv, int wbv, int wr, int ov, int jc, int sc);
        obs_t r;
        r.pc_en   = 1'(pc);
        r.ifid_en = 1'(fi);
        r.flush   = 1'(fl);
        r.jsel    = 1'(js);
        r.fa      = 2'(fa);
        r.fb      = 2'(fb);
        r.exv     = 1'(exv);
        r.wbv     = 1'(wbv);
        r.wr      = 1'(wr);
        r.ov      = 1'(ov);
        r.jc      = 8'(jc);
        r.sc      = 8'(sc);
        return r;
    endfunction

    task automatic step(input string nm, input int v, input int op, input int rs,
                        input int rt, input int rd, input int rdy, input obs_t x);
        @(negedge clk);
        id_valid  = 1'(v);
        id_opcode = 2'(op);
        id_rs     = 3'(rs);
        id_rt     = 3'(rt);
        id_rd     = 3'(rd);
        out_ready = 1'(rdy);
        sb.push_back('{nm, x});
    endtask

    task automatic idle(input string nm, input obs_t x);
        step(nm, 0, 2, 0, 0, 0, 1, x);
    endtask

    // Monitor: compares the DUT against the oldest expected snapshot,
    // sampled between the input change and the next rising edge.
    initial begin
        obs_t  act;
        item_t it;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {pc_en, ifid_en, ifid_flush, pc_jmp_select, fwd_a, fwd_b,
                       ex_valid, wb_valid, wb_reg_write, out_valid, jump_cnt, stall_cnt};
                n_vec++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h required %h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        id_valid  = 1'b0;
        id_opcode = 2'b10;
        id_rs     = '0;
        id_rt     = '0;
        id_rd     = '0;
        out_ready = 1'b1;

        step("reset_state", 0, 2, 0, 0, 0, 1, o(1,1,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #2 rst_n = 1'b1;

        // ALU rd=3 then consumer of r3 on both operands
        step("t1_alu_rd3",  1, 1, 1, 2, 3, 1, o(1,1,0,0,0,0,0,0,0,0,0,0));
        step("t1_fwd_ex",   1, 1, 3, 3, 4, 1, o(1,1,0,0,1,1,1,0,0,0,0,0));
        idle("t1_wr_rd3",                     o(1,1,0,0,0,0,1,1,1,0,0,0));
        idle("t1_wr_rd4",                     o(1,1,0,0,0,0,0,1,1,0,0,0));
        idle("t1_drain",                      o(1,1,0,0,0,0,0,0,0,0,0,0));

        // WB forwarding across a NOP, then EX-over-WB priority
        step("t2_alu_rd2",   1, 1, 5, 6, 2, 1, o(1,1,0,0,0,0,0,0,0,0,0,0));
        step("t2_nop",       1, 2, 0, 0, 0, 1, o(1,1,0,0,0,0,1,0,0,0,0,0));
        step("t2_fwd_wb",    1, 1, 2, 7, 1, 1, o(1,1,0,0,2,0,1,1,1,0,0,0));
        step("t2_alu_rd2_a", 1, 1, 4, 5, 2, 1, o(1,1,0,0,0,0,1,1,0,0,0,0));
        step("t2_alu_rd2_b", 1, 1, 4, 5, 2, 1, o(1,1,0,0,0,0,1,1,1,0,0,0));
        step("t2_ex_wins",   1, 1, 4, 2, 6, 1, o(1,1,0,0,0,1,1,1,1,0,0,0));
        idle("t2_drain_a",                     o(1,1,0,0,0,0,1,1,1,0,0,0));
        idle("t2_drain_b",                     o(1,1,0,0,0,0,0,1,1,0,0,0));
        idle("t2_drain_c",                     o(1,1,0,0,0,0,0,0,0,0,0,0));

        // Jump: redirect + flush for one cycle, never writes or forwards
        step("t4_jump",      1, 3, 0, 0, 7, 1, o(1,1,1,1,0,0,0,0,0,0,0,0));
        idle("t4_bubble",                      o(1,1,0,0,0,0,1,0,0,0,1,0));
        step("t4_jmp_nowr",  1, 1, 7, 7, 3, 1, o(1,1,0,0,0,0,0,1,0,0,1,0));
        idle("t4_drain_a",                     o(1,1,0,0,0,0,1,0,0,0,1,0));
        idle("t4_drain_b",                     o(1,1,0,0,0,0,0,1,1,0,1,0));

        // Output op stalls 3 cycles in WB with a jump waiting in ID
        step("t3_aluout",    1, 0, 1, 1, 5, 1, o(1,1,0,0,0,0,0,0,0,0,1,0));
        step("t3_alu_rd6",   1, 1, 5, 0, 6, 1, o(1,1,0,0,1,0,1,0,0,0,1,0));
        for (int k = 0; k < 3; k++) begin
            step("t3_stall", 1, 3, 6, 5, 0, 0, o(0,0,0,0,1,2,1,1,0,1,1,k));
        end
        step("t3_release",   1, 3, 6, 5, 0, 1, o(1,1,1,1,1,2,1,1,1,1,1,3));
        idle("t3_after_a",                     o(1,1,0,0,0,0,1,1,1,0,2,3));
        idle("t3_after_b",                     o(1,1,0,0,0,0,0,1,0,0,2,3));
        idle("t3_after_c",                     o(1,1,0,0,0,0,0,0,0,0,2,3));

        // 300 jumps, each followed by its flushed slot
        for (int i = 0; i < 300; i++) begin
            int jc_now;
            int jc_next;
            jc_now  = (2 + i > 255) ? 255 : 2 + i;
            jc_next = (3 + i > 255) ? 255 : 3 + i;
            step("t5_jump", 1, 3, 0, 0, 0, 1, o(1,1,1,1,0,0,0,(i > 0) ? 1 : 0,0,0,jc_now,3));
            idle("t5_bubble",                 o(1,1,0,0,0,0,1,0,0,0,jc_next,3));
        end
        idle("t5_saturated",                   o(1,1,0,0,0,0,0,1,0,0,255,3));

        // Async reset in the middle of a stall
        step("t6_aluout",    1, 0, 0, 0, 4, 1, o(1,1,0,0,0,0,0,0,0,0,255,3));
        step("t6_alu",       1, 1, 4, 4, 1, 1, o(1,1,0,0,1,1,1,0,0,0,255,3));
        step("t6_stall_a",   1, 1, 4, 1, 2, 0, o(0,0,0,0,2,1,1,1,0,1,255,3));
        step("t6_stall_b",   1, 1, 4, 1, 2, 0, o(0,0,0,0,2,1,1,1,0,1,255,4));
        @(negedge clk);
        #1 rst_n = 1'b0;
        sb.push_back('{"t6_async_rst", o(1,1,0,0,0,0,0,0,0,0,0,0)});
        @(posedge clk);
        #2 rst_n = 1'b1;
        step("t6_first",     1, 1, 4, 4, 4, 1, o(1,1,0,0,0,0,0,0,0,0,0,0));
        step("t6_fwd_after", 1, 1, 4, 0, 5, 1, o(1,1,0,0,1,0,1,0,0,0,0,0));
        idle("t6_drain",                       o(1,1,0,0,0,0,1,1,1,0,0,0));

        repeat (2) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
